nrisc_fetch_queue: RTL
======================

NRISC_FETCH_QUEUE -- requirements
Module: nrisc_fetch_queue

Interface
REQ-001 SHALL have parameters: TAM, 16, address width; DEPTH, 4, queue entries (power of 2, min 2); RESET_PC, 0, first fetch address.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have: IDATA_CORE_addr  out  TAM  fetch address to instruction memory.
REQ-005 SHALL have: IDATA_req  out  1  read request; data returns exactly 1 cycle later.
REQ-006 SHALL have: IDATA_CORE_out  in  16  instruction word for the previous cycle's request.
REQ-007 SHALL have: CORE_flush  in  1  redirect (branch, call, return, interrupt), single-cycle pulse.
REQ-008 SHALL have: CORE_flush_addr  in  TAM  redirect target, sampled with CORE_flush.
REQ-009 SHALL have: CORE_ready  in  1  core consumes head entry this cycle.
REQ-010 SHALL have: CORE_InstructionIN  out  16  head instruction; 16'h0000 (NOP) when CORE_valid=0.
REQ-011 SHALL have: CORE_valid  out  1  head entry present.
REQ-012 SHALL have: CORE_PC  out  TAM  address of head instruction; 0 when CORE_valid=0.
REQ-013 SHALL have: QUEUE_count  out  log2(DEPTH)+1  stored entries.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, FULL, FLUSH.
REQ-015 IDLE: entered on reset; SHALL go to FETCH after one cycle with IDATA_req=0.
REQ-016 FETCH: IDATA_req=1 when QUEUE_count + in-flight < DEPTH; otherwise SHALL go to FULL with IDATA_req=0.
REQ-017 FULL: SHALL return to FETCH in the cycle after a pop makes a credit available.
REQ-018 Each issued request SHALL advance the fetch address by 1 (mod 2^TAM, 16'hFFFF wraps to 0).
REQ-019 A response SHALL be pushed tail-side with its request address the cycle after issue.
REQ-020 Pop occurs when CORE_valid & CORE_ready; simultaneous push and pop SHALL keep QUEUE_count unchanged, including when full.
REQ-021 Overflow SHALL be impossible by credit accounting; underflow (ready while empty) SHALL be ignored.
REQ-022 CORE_flush SHALL, in the same edge, empty the queue, kill the in-flight response, load the fetch address from CORE_flush_addr, and enter FLUSH.
REQ-023 FLUSH: IDATA_req=1 at the new address; SHALL go to FETCH next cycle; the first new instruction is valid 2 cycles after the flush edge.
REQ-024 CORE_flush SHALL take priority over push and pop in the same cycle; a pop in the flush cycle is discarded.
REQ-025 CORE_flush during FLUSH SHALL restart redirect with the newer address.
REQ-026 In-order delivery SHALL hold: CORE_PC of consecutive pops increments by 1 between flushes.

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, fetch address RESET_PC, IDATA_req=0, QUEUE_count=0, CORE_valid=0, CORE_InstructionIN=0, CORE_PC=0, in-flight cleared.
REQ-028 rst asserted mid-operation SHALL discard queue and in-flight data; no response from before reset is ever delivered.
REQ-029 Fetching SHALL restart from RESET_PC via IDLE on the first edge after rst deassertion.

Configuration
REQ-030 Macro NRISC_FETCH_BYPASS_EN defined: a response arriving to an empty queue SHALL be presented on CORE_InstructionIN/CORE_PC/CORE_valid in the same cycle; if CORE_ready=1 it is not stored.
REQ-031 NRISC_FETCH_BYPASS_EN undefined: every response SHALL be stored first and become visible the cycle after arrival (redirect-to-valid latency 2 cycles per REQ-023; with bypass, 1 cycle).

Verification
REQ-032 Reset then CORE_ready=1, memory returns addr+16'h1000 -> CORE_PC 0,1,2,3... with instructions 16'h1000,16'h1001,... one per cycle after warm-up.
REQ-033 CORE_ready=0 for 10 cycles -> QUEUE_count saturates at 4, IDATA_req=0 in FULL, no duplicate or lost PC after ready returns.
REQ-034 CORE_flush with addr 16'h0040 while 3 entries queued and 1 in flight -> next valid CORE_PC=16'h0040, none of old addresses delivered.
REQ-035 Flush to 16'hFFFE, ready=1 -> CORE_PC sequence 16'hFFFE, 16'hFFFF, 16'h0000.
REQ-036 rst pulse asynchronously mid-stream (between edges) -> outputs zero immediately; after release first CORE_PC=RESET_PC.
REQ-037 Run REQ-032 and REQ-034 with and without NRISC_FETCH_BYPASS_EN -> first valid cycle differs by exactly 1.

Source files
------------

// File: rtl/nrisc_fetch_queue_if.sv
// Fetch queue bus: instruction-memory side plus core-side handshake.
// master = fetch queue, slave = memory/core environment.
interface nrisc_fetch_queue_if #(
    parameter int TAM   = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TAM-1:0] IDATA_CORE_addr;
    logic           IDATA_req;
    logic [15:0]    IDATA_CORE_out;
    logic           CORE_flush;
    logic [TAM-1:0] CORE_flush_addr;
    logic           CORE_ready;
    logic [15:0]    CORE_InstructionIN;
    logic           CORE_valid;
    logic [TAM-1:0] CORE_PC;
    logic [CW-1:0]  QUEUE_count;

    modport master (
        output IDATA_CORE_addr,
        output IDATA_req,
        input  IDATA_CORE_out,
        input  CORE_flush,
        input  CORE_flush_addr,
        input  CORE_ready,
        output CORE_InstructionIN,
        output CORE_valid,
        output CORE_PC,
        output QUEUE_count
    );

    modport slave (
        input  IDATA_CORE_addr,
        input  IDATA_req,
        output IDATA_CORE_out,
        output CORE_flush,
        output CORE_flush_addr,
        output CORE_ready,
        input  CORE_InstructionIN,
        input  CORE_valid,
        input  CORE_PC,
        input  QUEUE_count
    );
endinterface

// File: rtl/nrisc_fetch_queue.sv
// Instruction prefetch queue with credit-based fetch and flush redirect.
// Ports: clk, rst (async active-high), bus (nrisc_fetch_queue_if.master):
//   IDATA_* = 1-cycle-latency instruction memory, CORE_* = core handshake,
//   QUEUE_count = stored entries.
// Option: define NRISC_FETCH_BYPASS_EN to present a response arriving to
//   an empty queue in the same cycle (skips storage when consumed).
module nrisc_fetch_queue #(
    parameter int             TAM      = 16,
    parameter int             DEPTH    = 4,
    parameter logic [TAM-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    nrisc_fetch_queue_if.master bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] L_DEPTH = CW1'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FULL, FLUSH} state_t;

    state_t         r_state;
    logic [TAM-1:0] r_pc;
    logic           r_inf;
    logic [TAM-1:0] r_inf_addr;
    logic [15:0]    r_q_ins [DEPTH];
    logic [TAM-1:0] r_q_pc  [DEPTH];
    logic [AW-1:0]  r_rd;
    logic [AW-1:0]  r_wr;
    logic [CW-1:0]  r_cnt;

    logic           w_flush;
    logic           w_empty;
    logic [CW:0]    w_used;
    logic           w_credit;
    logic           w_req;
    logic           w_byp;
    logic           w_valid;
    logic           w_pop;
    logic           w_pop_q;
    logic           w_push;
    logic [CW-1:0]  w_cnt_nxt;
    logic [15:0]    w_head_ins;
    logic [TAM-1:0] w_head_pc;

    assign w_flush = bus.CORE_flush;
    assign w_empty = (r_cnt == '0);

    // Stored entries plus the response still on its way must fit.
    assign w_used   = {1'b0, r_cnt} + {{CW{1'b0}}, r_inf};
    assign w_credit = (w_used < L_DEPTH);

    assign w_req = (r_state == FLUSH) |
                   ((r_state == FETCH) & w_credit);

`ifdef NRISC_FETCH_BYPASS_EN
    assign w_byp = w_empty & r_inf;
`else
    assign w_byp = 1'b0;
`endif

    assign w_valid    = ~w_empty | w_byp;
    assign w_head_ins = w_byp ? bus.IDATA_CORE_out : r_q_ins[r_rd];
    assign w_head_pc  = w_byp ? r_inf_addr : r_q_pc[r_rd];

    // Flush wins over both ends of the queue.
    assign w_pop   = w_valid & bus.CORE_ready & ~w_flush;
    assign w_pop_q = w_pop & ~w_empty;
    assign w_push  = r_inf & ~w_flush & ~(w_byp & w_pop);

    assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop_q);

    assign bus.IDATA_req          = w_req;
    assign bus.IDATA_CORE_addr    = r_pc;
    assign bus.CORE_valid         = w_valid;
    assign bus.CORE_InstructionIN = w_valid ? w_head_ins : 16'h0000;
    assign bus.CORE_PC            = w_valid ? w_head_pc : '0;
    assign bus.QUEUE_count        = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_inf      <= 1'b0;
            r_inf_addr <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_cnt      <= '0;
        end else begin
            // A request issued in the flush cycle is dropped on return.
            r_inf <= w_req & ~w_flush;
            if (w_req) begin
                r_inf_addr <= r_pc;
            end
            if (w_flush) begin
                r_pc    <= bus.CORE_flush_addr;
                r_rd    <= '0;
                r_wr    <= '0;
                r_cnt   <= '0;
                r_state <= FLUSH;
            end else begin
                if (w_req) begin
                    r_pc <= r_pc + TAM'(1);
                end
                if (w_push) begin
                    r_wr <= r_wr + AW'(1);
                end
                if (w_pop_q) begin
                    r_rd <= r_rd + AW'(1);
                end
                r_cnt <= w_cnt_nxt;
                unique case (r_state)
                    IDLE:  r_state <= FETCH;
                    FETCH: if (!w_credit) r_state <= FULL;
                    // Nothing is in flight while FULL.
                    FULL:  if ({1'b0, w_cnt_nxt} < L_DEPTH) r_state <= FETCH;
                    FLUSH: r_state <= FETCH;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Payload storage needs no reset: it is only read behind CORE_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_ins[r_wr] <= bus.IDATA_CORE_out;
            r_q_pc[r_wr]  <= r_inf_addr;
        end
    end
endmodule
